serial_comparator: RTL and testbench

Parametrised, bit-serial magnitude comparator, successor to the 1-bit combinational comparator. It compares two WIDTH-bit operands MSB-first, one bit per clock, in unsigned or two's-complement signed mode. It terminates early at the first differing bit and reports equal/lesser/greater through a start/busy/done handshake. It sits in the arithmetic datapath library as a low-area comparator for control logic that can tolerate multi-cycle latency.

---
 rtl/serial_comparator.sv | 150 +++++++++++++++
 tb/tb_serial_comparator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_comparator
// Purpose  : Bit-serial magnitude comparator. Compares two WIDTH-bit operands
//            MSB-first, one bit per clock, in unsigned or two's-complement
//            mode, stopping at the first differing bit.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            start        - request, sampled only while idle
//            signed_mode  - 0 = unsigned, 1 = two's-complement (latched)
//            a, b         - operands (latched with start)
//            busy         - comparison in progress
//            done         - one-cycle pulse, result valid
//            equal/lesser/greater - registered result flags (a vs b)
// Revision : 1.0 - initial release
// ============================================================================
module serial_comparator #(
  parameter int WIDTH = 8   // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             lesser,
  output logic             greater
);

  localparam int              c_idx_w   = $clog2(WIDTH);
  localparam logic [c_idx_w-1:0] c_msb_idx = c_idx_w'(WIDTH - 1);
  localparam logic [c_idx_w-1:0] c_one     = c_idx_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  state_t               r_state,   w_state_n;
  logic [WIDTH-1:0]     r_a,       w_a_n;
  logic [WIDTH-1:0]     r_b,       w_b_n;
  logic                 r_signed,  w_signed_n;
  logic [c_idx_w-1:0]   r_idx,     w_idx_n;
  logic                 r_busy,    w_busy_n;
  logic                 r_done,    w_done_n;
  logic                 r_equal,   w_equal_n;
  logic                 r_lesser,  w_lesser_n;
  logic                 r_greater, w_greater_n;

  logic                 w_bit_a;
  logic                 w_bit_b;
  logic                 w_a_wins;

  assign w_bit_a = r_a[r_idx];
  assign w_bit_b = r_b[r_idx];

  // At the sign bit a set bit means negative in signed mode, so the operand
  // holding the 1 is the smaller one. Below the sign bit the weight is
  // positive in both modes.
  assign w_a_wins = (r_signed && (r_idx == c_msb_idx)) ? w_bit_b : w_bit_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_equal   <= 1'b0;
      r_lesser  <= 1'b0;
      r_greater <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_signed  <= w_signed_n;
      r_idx     <= w_idx_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_equal   <= w_equal_n;
      r_lesser  <= w_lesser_n;
      r_greater <= w_greater_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_signed_n  = r_signed;
    w_idx_n     = r_idx;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;          // done is a single-cycle pulse
    w_equal_n   = r_equal;
    w_lesser_n  = r_lesser;
    w_greater_n = r_greater;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_n       = a;
          w_b_n       = b;
          w_signed_n  = signed_mode;
          w_idx_n     = c_msb_idx;
          w_equal_n   = 1'b0;
          w_lesser_n  = 1'b0;
          w_greater_n = 1'b0;
          w_busy_n    = 1'b1;
          w_state_n   = ST_CMP;
        end
      end

      ST_CMP: begin
        if (w_bit_a != w_bit_b) begin
          w_greater_n = w_a_wins;
          w_lesser_n  = ~w_a_wins;
          w_done_n    = 1'b1;
          w_busy_n    = 1'b0;
          w_state_n   = ST_IDLE;
        end else if (r_idx == '0) begin
          // All bits matched; idx never wraps below zero.
          w_equal_n   = 1'b1;
          w_done_n    = 1'b1;
          w_busy_n    = 1'b0;
          w_state_n   = ST_IDLE;
        end else begin
          w_idx_n     = r_idx - c_one;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign equal   = r_equal;
  assign lesser  = r_lesser;
  assign greater = r_greater;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_comparator
// Purpose  : Self-checking bench for serial_comparator (WIDTH = 8). Directed
//            scenarios plus randomized back-to-back traffic checked against a
//            behavioural model using plain signed/unsigned arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         equal;
  logic         lesser;
  logic         greater;

  int tests = 0;
  int fails = 0;

  serial_comparator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .equal       (equal),
    .lesser      (lesser),
    .greater     (greater)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic m);
    int vx, vy;
    vx = m ? int'($signed(x)) : int'(x);
    vy = m ? int'($signed(y)) : int'(y);
    return {vx == vy, vx < vy, vx > vy};   // {equal, lesser, greater}
  endfunction

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return W - i;
    return W;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  // Drives one start pulse; returns half a cycle after the sampling edge with
  // the inputs scrambled so any late use of them shows up as a wrong result.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic m);
    a = ta; b = tb_v; signed_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
  endtask

  // Counts cycles until done; n = -1 on timeout. bad counts cycles where
  // busy and done were not exact complements.
  task automatic wait_done(output int n, output int bad);
    n = -1; bad = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (busy === done) bad++;
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34; signed_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, done, equal, lesser, greater} !== 5'b0) begin
        fails++;
        $display("FAIL reset_hold: outputs=%b required=00000", {busy, done, equal, lesser, greater});
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, done, equal, lesser, greater} !== 5'b0) begin
        fails++;
        $display("FAIL reset_release: outputs=%b required=00000", {busy, done, equal, lesser, greater});
      end
    end
  endtask

  task automatic test_equal;
    int n, bad;
    issue(8'h5A, 8'h5A, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL equal_busy: busy=%b required=1", busy);
    end
    wait_done(n, bad);
    tests++;
    if (n !== 8) begin
      fails++; $display("FAIL equal_latency: cycles=%0d required=8", n);
    end
    tests++;
    if ({equal, lesser, greater} !== 3'b100 || bad !== 0) begin
      fails++; $display("FAIL equal_result: elg=%b badhs=%0d required elg=100 badhs=0",
                        {equal, lesser, greater}, bad);
    end
    @(negedge clk);
    tests++;
    if ({done, equal, lesser, greater} !== 4'b0100) begin
      fails++; $display("FAIL equal_hold: d_elg=%b required=0100", {done, equal, lesser, greater});
    end
  endtask

  task automatic test_msb;
    logic [W-1:0] va [3] = '{8'h80, 8'h80, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h7F, 8'h7F, 8'h80};
    logic         vm [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]   ve [3] = '{3'b001, 3'b010, 3'b001};
    int n, bad;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vm[i]);
      wait_done(n, bad);
      tests++;
      if (n !== 1 || {equal, lesser, greater} !== ve[i] || bad !== 0) begin
        fails++;
        $display("FAIL msb_case%0d: cycles=%0d elg=%b badhs=%0d required cycles=1 elg=%b",
                 i, n, {equal, lesser, greater}, bad, ve[i]);
      end
    end
  endtask

  task automatic test_lsb;
    int n, bad;
    issue(8'h13, 8'h12, 1'b0);
    wait_done(n, bad);
    tests++;
    if (n !== 8 || {equal, lesser, greater} !== 3'b001 || bad !== 0) begin
      fails++; $display("FAIL lsb_unsigned: cycles=%0d elg=%b required cycles=8 elg=001",
                        n, {equal, lesser, greater});
    end
    issue(8'hF2, 8'hF3, 1'b1);
    wait_done(n, bad);
    tests++;
    if (n !== 8 || {equal, lesser, greater} !== 3'b010 || bad !== 0) begin
      fails++; $display("FAIL lsb_signed: cycles=%0d elg=%b required cycles=8 elg=010",
                        n, {equal, lesser, greater});
    end
  endtask

  task automatic test_handshake;
    int n, bad;
    // 0x33 vs 0x30: first difference at bit 1 -> 7 cycles, greater.
    issue(8'h33, 8'h30, 1'b0);
    n = -1;
    for (int c = 1; c <= 3 * W; c++) begin
      if (c == 3) begin
        a = 8'h01; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
    start = 1'b0;
    tests++;
    if (n !== 7 || {equal, lesser, greater} !== 3'b001) begin
      fails++; $display("FAIL hs_ignore_busy_start: cycles=%0d elg=%b required cycles=7 elg=001",
                        n, {equal, lesser, greater});
    end
    // Back-to-back: start raised in the done cycle.
    issue(8'h01, 8'h02, 1'b0);
    tests++;
    if ({busy, done, equal, lesser, greater} !== 5'b10000) begin
      fails++; $display("FAIL hs_b2b_clear: b_d_elg=%b required=10000",
                        {busy, done, equal, lesser, greater});
    end
    wait_done(n, bad);
    tests++;
    if (n !== 7 || {equal, lesser, greater} !== 3'b010 || bad !== 0) begin
      fails++; $display("FAIL hs_b2b_result: cycles=%0d elg=%b required cycles=7 elg=010",
                        n, {equal, lesser, greater});
    end
  endtask

  task automatic test_reset_mid;
    int n, bad;
    int seen_done;
    issue(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, equal, lesser, greater} !== 5'b0) begin
      fails++; $display("FAIL rstmid_abort: outputs=%b required=00000",
                        {busy, done, equal, lesser, greater});
    end
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      if (i == 2) rst_n = 1'b1;
    end
    tests++;
    if (seen_done !== 0 || {equal, lesser, greater} !== 3'b0) begin
      fails++; $display("FAIL rstmid_quiet: active_cycles=%0d elg=%b required 0 and 000",
                        seen_done, {equal, lesser, greater});
    end
    issue(8'h00, 8'h00, 1'b0);
    wait_done(n, bad);
    tests++;
    if (n !== 8 || {equal, lesser, greater} !== 3'b100 || bad !== 0) begin
      fails++; $display("FAIL rstmid_restart: cycles=%0d elg=%b required cycles=8 elg=100",
                        n, {equal, lesser, greater});
    end
  endtask

  task automatic test_random;
    int n, bad;
    logic [W-1:0] ra, rb;
    logic         rm;
    logic [2:0]   exp_res;
    int           exp_n;
    for (int it = 0; it < 60; it++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      rm = 1'($urandom);
      exp_res = ref_res(ra, rb, rm);
      exp_n   = ref_lat(ra, rb);
      issue(ra, rb, rm);
      wait_done(n, bad);
      tests++;
      if (n !== exp_n || {equal, lesser, greater} !== exp_res || bad !== 0) begin
        fails++;
        $display("FAIL random_%0d a=%h b=%h s=%b: cycles=%0d elg=%b badhs=%0d required cycles=%0d elg=%b",
                 it, ra, rb, rm, n, {equal, lesser, greater}, bad, exp_n, exp_res);
      end
      // Occasionally idle a cycle: done must drop while results hold.
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        tests++;
        if ({busy, done, equal, lesser, greater} !== {2'b00, exp_res}) begin
          fails++;
          $display("FAIL random_hold_%0d: b_d_elg=%b required=00%b",
                   it, {busy, done, equal, lesser, greater}, exp_res);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb();
    test_lsb();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
